// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// CON bit positions and the TX/RX state encodings.
package uart_pkg;

    // Register offsets from BASE_ADDR (word aligned)
    localparam logic [31:0] OFF_TXD = 32'h0000_0000;
    localparam logic [31:0] OFF_RXD = 32'h0000_0004;
    localparam logic [31:0] OFF_CON = 32'h0000_0008;

    // CON register bit positions
    localparam int unsigned CON_TX_IRQ_EN = 0;
    localparam int unsigned CON_RX_IRQ_EN = 1;
    localparam int unsigned CON_TX_DONE   = 2;
    localparam int unsigned CON_RX_VALID  = 3;
    localparam int unsigned CON_TX_BUSY   = 4;
    localparam int unsigned CON_OVERRUN   = 5;
    localparam int unsigned CON_FRAME_ERR = 6;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// Serial receiver: 2-flop synchroniser, start-edge detect, mid-bit sampling
// of an 8N1 LSB-first frame. Emits one-cycle pulses for a good byte or a
// framing error; the byte stays on data_o until the next frame shifts in.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Synchronise the asynchronous line and keep one extra stage for edge detect
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State register, bit timer, bit counter, shift register and output pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next state: half-bit to the start sample, then full bits between samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Stop-bit sample decides between a good byte and a framing error
    always_comb begin
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == RX_STOP && cnt_q == CNT_FULL) begin
            valid_d = sync2_q;
            ferr_d  = !sync2_q;
        end
    end

    assign data_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART on the MEM-stage peripheral bus: TXD/RXD/CON
// registers, transmit FSM and a registered level interrupt.
module uart_peripheral
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        irq
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      TXD_ADDR = BASE_ADDR + OFF_TXD;
    localparam logic [31:0]      RXD_ADDR = BASE_ADDR + OFF_RXD;
    localparam logic [31:0]      CON_ADDR = BASE_ADDR + OFF_CON;

    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_busy, tx_frame_end;

    logic tx_irq_en_q, tx_irq_en_d;
    logic rx_irq_en_q, rx_irq_en_d;
    logic tx_done_q, tx_done_d;
    logic rx_valid_q, rx_valid_d;
    logic overrun_q, overrun_d;
    logic frame_err_q, frame_err_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic irq_q, irq_d;

    logic [7:0] rx_byte;
    logic       rx_byte_valid, rx_frame_err;

    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], addr[1:0]};

    // Word-address decode; byte offset within the word is ignored
    always_comb begin
        sel_txd = (addr[31:2] == TXD_ADDR[31:2]);
        sel_rxd = (addr[31:2] == RXD_ADDR[31:2]);
        sel_con = (addr[31:2] == CON_ADDR[31:2]);
        wr_txd  = mem_write && sel_txd;
        wr_con  = mem_write && sel_con;
        rd_rxd  = mem_read && sel_rxd;
    end

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (clk),
        .rst_i      (reset_b),
        .rxd_i      (uart_rxd),
        .data_o     (rx_byte),
        .valid_o    (rx_byte_valid),
        .frame_err_o(rx_frame_err)
    );

    // TX state register with its bit timer, bit counter and shift register
    always_ff @(posedge clk) begin
        if (reset_b) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // TX next state: accept a byte only when idle, each state holds one bit time
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (wr_txd) begin
                    tx_shift_d = wdata[7:0];
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_FULL) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_FULL) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_FULL) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX outputs: line level, busy flag and end-of-frame strobe
    always_comb begin
        uart_txd     = 1'b1;
        tx_busy      = 1'b1;
        tx_frame_end = 1'b0;
        case (tx_state_q)
            TX_IDLE:  tx_busy = 1'b0;
            TX_START: uart_txd = 1'b0;
            TX_DATA:  uart_txd = tx_shift_q[0];
            TX_STOP:  tx_frame_end = (tx_cnt_q == CNT_FULL);
            default:  tx_busy = 1'b0;
        endcase
    end

    // Status/control next values: clears applied first so a same-cycle set wins
    always_comb begin
        tx_irq_en_d = wr_con ? wdata[CON_TX_IRQ_EN] : tx_irq_en_q;
        rx_irq_en_d = wr_con ? wdata[CON_RX_IRQ_EN] : rx_irq_en_q;

        tx_done_d = tx_done_q;
        if (wr_con && wdata[CON_TX_DONE]) tx_done_d = 1'b0;
        if (tx_frame_end) tx_done_d = 1'b1;

        rx_valid_d = rx_valid_q;
        if (rd_rxd) rx_valid_d = 1'b0;
        if (rx_byte_valid) rx_valid_d = 1'b1;

        overrun_d = overrun_q;
        if (wr_con && wdata[CON_OVERRUN]) overrun_d = 1'b0;
        if (rx_byte_valid && rx_valid_q && !rd_rxd) overrun_d = 1'b1;

        frame_err_d = frame_err_q;
        if (wr_con && wdata[CON_FRAME_ERR]) frame_err_d = 1'b0;
        if (rx_frame_err) frame_err_d = 1'b1;

        rx_data_d = rx_byte_valid ? rx_byte : rx_data_q;

        irq_d = (tx_done_q && tx_irq_en_q) || (rx_valid_q && rx_irq_en_q);
    end

    // Register file and interrupt flop
    always_ff @(posedge clk) begin
        if (reset_b) begin
            tx_irq_en_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            tx_irq_en_q <= tx_irq_en_d;
            rx_irq_en_q <= rx_irq_en_d;
            tx_done_q   <= tx_done_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            irq_q       <= irq_d;
        end
    end

    // Combinational read mux; TXD and unmapped addresses read as zero
    always_comb begin
        rdata = '0;
        if (sel_rxd) begin
            rdata[7:0] = rx_data_q;
        end else if (sel_con) begin
            rdata[CON_TX_IRQ_EN] = tx_irq_en_q;
            rdata[CON_RX_IRQ_EN] = rx_irq_en_q;
            rdata[CON_TX_DONE]   = tx_done_q;
            rdata[CON_RX_VALID]  = rx_valid_q;
            rdata[CON_TX_BUSY]   = tx_busy;
            rdata[CON_OVERRUN]   = overrun_q;
            rdata[CON_FRAME_ERR] = frame_err_q;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_uart_peripheral.sv
// Bench for uart_peripheral: event-level register model, read-data scoreboard
// and a serial TX frame monitor.
module tb_uart_peripheral;

    localparam int unsigned CPB   = 16;
    localparam logic [31:0] BASE  = 32'h4000_0018;
    localparam logic [31:0] A_TXD = BASE;
    localparam logic [31:0] A_RXD = BASE + 32'h4;
    localparam logic [31:0] A_CON = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [31:0] addr, wdata, rdata;
    logic        mem_read, mem_write;
    logic        uart_rxd, uart_txd, irq;

    uart_peripheral #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .addr     (addr),
        .wdata    (wdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .rdata    (rdata),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t       rd_q[$];
    logic [7:0] tx_q[$];
    int         tx_frames = 0;

    // Behavioural register model
    bit         m_tx_en, m_rx_en, m_tx_done, m_rx_valid, m_overrun, m_ferr;
    logic [7:0] m_rx_data;

    function automatic logic [31:0] m_con();
        return {25'd0, m_ferr, m_overrun, 1'b0, m_rx_valid, m_tx_done, m_rx_en, m_tx_en};
    endfunction

    function automatic logic [31:0] m_irq();
        return 32'((m_tx_done && m_tx_en) || (m_rx_valid && m_rx_en));
    endfunction

    task automatic model_reset();
        m_tx_en = 0; m_rx_en = 0; m_tx_done = 0; m_rx_valid = 0; m_overrun = 0; m_ferr = 0;
        m_rx_data = 8'h00;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; mem_write = 1'b1;
        @(posedge clk);
        #1 mem_write = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.val  = exp;
        rd_q.push_back(e);
        @(negedge clk);
        addr = a; mem_read = 1'b1;
        @(posedge clk);
        #1 mem_read = 1'b0; addr = '0;
    endtask

    task automatic read_con(input string name);
        bus_read(A_CON, name, m_con());
    endtask

    task automatic read_rxd(input logic [31:0] a, input string name);
        bus_read(a, name, {24'd0, m_rx_data});
        m_rx_valid = 0;
    endtask

    task automatic write_con(input logic [31:0] d);
        bus_write(A_CON, d);
        m_tx_en = d[0];
        m_rx_en = d[1];
        if (d[2]) m_tx_done = 0;
        if (d[5]) m_overrun = 0;
        if (d[6]) m_ferr = 0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fr[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        if (stop_ok) begin
            if (m_rx_valid) m_overrun = 1;
            m_rx_valid = 1;
            m_rx_data  = b;
        end else begin
            m_ferr = 1;
        end
    endtask

    task automatic wait_tx(input int target);
        int n;
        n = 0;
        while (tx_frames < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (tx_frames < target) check("tx_frame_timeout", 32'(tx_frames), 32'(target));
        repeat (3) @(posedge clk);
    endtask

    task automatic send_tx(input logic [7:0] b);
        logic [31:0] d;
        int target;
        d = $urandom();
        d[7:0] = b;
        tx_q.push_back(b);
        target = tx_frames + 1;
        bus_write(A_TXD, d);
        wait_tx(target);
        m_tx_done = 1;
    endtask

    // Read-data monitor: compares rdata on every bus read against the scoreboard
    initial begin : rd_mon
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mem_read === 1'b1) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_unexpected: got 0x%08h, expected no read", rdata);
                end else begin
                    e = rd_q.pop_front();
                    check(e.name, rdata, e.val);
                end
            end
        end
    end

    // TX monitor: captures every cycle of a frame, checks bit timing and the byte
    initial begin : tx_mon
        logic       s [160];
        bit         aborted, shape_ok;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (uart_txd === 1'b0 && reset_b === 1'b0) begin
                aborted = 0;
                for (int i = 0; i < 160; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        #2;
                    end
                    s[i] = uart_txd;
                    if (reset_b !== 1'b0) aborted = 1;
                end
                if (!aborted) begin
                    shape_ok = 1;
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < CPB; j++)
                            if (s[k*CPB+j] !== s[k*CPB]) shape_ok = 0;
                    if (s[0] !== 1'b0 || s[9*CPB] !== 1'b1) shape_ok = 0;
                    for (int k = 0; k < 8; k++) got[k] = s[(k+1)*CPB];
                    check("tx_bit_timing", 32'(shape_ok), 32'd1);
                    if (tx_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL tx_unexpected_frame: got byte 0x%02h, expected no frame", got);
                    end else begin
                        check("tx_frame_byte", {24'd0, got}, {24'd0, tx_q.pop_front()});
                    end
                    tx_frames++;
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] b;
        int op;
        reset_b = 1'b1; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0; uart_rxd = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b0;

        check("reset_txd", 32'(uart_txd), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        read_con("reset_con");
        read_rxd(A_RXD, "reset_rxd");

        // TX of 0xA5 with an ignored write mid-frame; tx_done lands 160 cycles after accept
        tx_q.push_back(8'hA5);
        bus_write(A_TXD, 32'h0000_00A5);
        repeat (49) @(posedge clk);
        bus_write(A_TXD, 32'h0000_005A);
        repeat (109) @(posedge clk);
        bus_read(A_CON, "tx_busy_at_159", m_con() | 32'h10);
        m_tx_done = 1;
        read_con("tx_done_at_160");
        wait_tx(1);
        bus_read(A_TXD, "txd_reads_zero", 32'd0);

        // RX of 0x3C, read clears rx_valid
        send_rx(8'h3C, 1);
        read_con("rx_valid_set");
        read_rxd(A_RXD, "rx_data_3c");
        read_con("rx_valid_cleared");

        // rx irq, cleared one cycle after the read that clears rx_valid
        write_con(32'h0000_0006);
        send_rx(8'h55, 1);
        check("irq_rx_valid", 32'(irq), m_irq());
        read_rxd(A_RXD, "rx_data_55");
        check("irq_on_clear_edge", 32'(irq), 32'd1);
        @(posedge clk);
        #1 check("irq_after_clear", 32'(irq), m_irq());

        // Overrun: second byte kept, flag cleared by writing 1
        write_con(32'h0000_0000);
        send_rx(8'h11, 1);
        send_rx(8'h22, 1);
        read_con("overrun_set");
        read_rxd(A_RXD + 32'h3, "rx_data_22_alias");
        write_con(32'h0000_0020);
        read_con("overrun_cleared");

        // Framing error and a short glitch
        send_rx(8'($urandom()), 0);
        read_con("frame_err_set");
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        read_con("glitch_no_flags");
        send_rx(8'($urandom()), 1);
        read_rxd(A_RXD, "rx_after_glitch");
        write_con(32'h0000_0040);

        // Unmapped addresses
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        bus_write(BASE - 32'h4, 32'hFFFF_FFFF);
        bus_read(BASE + 32'hC, "unmapped_read_hi", 32'd0);
        bus_read(BASE - 32'h4, "unmapped_read_lo", 32'd0);
        read_con("unmapped_write_no_effect");

        // Randomised operations against the model
        for (int it = 0; it < 14; it++) begin
            op = $urandom_range(0, 4);
            b  = 8'($urandom());
            case (op)
                0: send_rx(b, 1);
                1: send_rx(b, 0);
                2: read_rxd(A_RXD + 32'($urandom_range(0, 3)), "rand_rxd");
                3: begin
                    write_con(32'($urandom_range(0, 127)));
                    read_con("rand_con");
                end
                default: send_tx(b);
            endcase
            repeat (2) @(posedge clk);
            #1 check("rand_irq", 32'(irq), m_irq());
        end
        read_con("rand_final_con");

        // Reset in the middle of data bit 3
        bus_write(A_TXD, 32'($urandom_range(0, 255)));
        repeat (CPB * 4 + 5) @(posedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1 reset_b = 1'b0;
        model_reset();
        check("reset_mid_tx_txd", 32'(uart_txd), 32'd1);
        check("reset_mid_tx_irq", 32'(irq), 32'd0);
        read_con("reset_mid_tx_con");
        repeat (200) @(posedge clk);
        send_tx(8'($urandom()));
        read_con("tx_after_reset_con");

        repeat (5) @(posedge clk);
        check("leftover_expectations", 32'(rd_q.size() + tx_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
